aes_encipher_block: RTL

Iterative AES-128/AES-256 encryption datapath. It consumes the round keys held by the key schedule by driving a round index and reading back the 128-bit round key. It shares the single 32-bit S-box word lookup with the key schedule, and the core-level mux grants it the S-box whenever the key schedule is not generating. It performs one SubBytes word per cycle plus one combined ShiftRows/MixColumns/AddRoundKey cycle per round.

---
 rtl/aes_encipher_block.sv | 135 +++++++++++++
 1 files changed

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/AES-256 encipher datapath.
// Each round takes four SubBytes cycles, one word per cycle, through the shared S-box.
// These are followed by one cycle that combines ShiftRows, MixColumns and AddRoundKey.
// The round index selects the round key, which comes back combinationally from the key memory.
module aes_encipher_block (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SBOX = 2'd1,
    MAIN = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   w;
  logic [3:0]   round_ctr;
  logic         keylen_reg;
  logic [127:0] block_reg;
  logic         ready_reg;

  logic [3:0]   nr;
  logic [127:0] sr_block;
  logic [127:0] mc_block;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    b0 = c[31:24];
    b1 = c[23:16];
    b2 = c[15:8];
    b3 = c[7:0];
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  // Column-major state: row r of column c is bits [127-32c-8r -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  // Round-final transforms and the round count selected by the latched key length.
  always_comb begin
    nr       = keylen_reg ? 4'd14 : 4'd10;
    sr_block = shift_rows(block_reg);
    mc_block = {mix_word(sr_block[127:96]), mix_word(sr_block[95:64]),
                mix_word(sr_block[63:32]),  mix_word(sr_block[31:0])};
  end

  // The shared S-box sees the current word while substituting; otherwise it sees word 0.
  always_comb begin
    sboxw = block_reg[127:96];
    if (state == SBOX) begin
      case (w)
        2'd0:    sboxw = block_reg[127:96];
        2'd1:    sboxw = block_reg[95:64];
        2'd2:    sboxw = block_reg[63:32];
        default: sboxw = block_reg[31:0];
      endcase
    end
  end

  // Round sequencer and state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      w          <= '0;
      round_ctr  <= '0;
      keylen_reg <= 1'b0;
      block_reg  <= '0;
      ready_reg  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (next) begin
            block_reg  <= block ^ round_key;
            keylen_reg <= keylen;
            round_ctr  <= 4'd1;
            w          <= '0;
            ready_reg  <= 1'b0;
            state      <= SBOX;
          end
        end
        SBOX: begin
          case (w)
            2'd0:    block_reg[127:96] <= new_sboxw;
            2'd1:    block_reg[95:64]  <= new_sboxw;
            2'd2:    block_reg[63:32]  <= new_sboxw;
            default: block_reg[31:0]   <= new_sboxw;
          endcase
          w <= w + 2'd1;
          if (w == 2'd3) begin
            state <= MAIN;
          end
        end
        MAIN: begin
          if (round_ctr == nr) begin
            block_reg <= sr_block ^ round_key;
            round_ctr <= '0;
            ready_reg <= 1'b1;
            state     <= IDLE;
          end else begin
            block_reg <= mc_block ^ round_key;
            round_ctr <= round_ctr + 4'd1;
            state     <= SBOX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign round     = round_ctr;
  assign new_block = block_reg;
  assign ready     = ready_reg;

endmodule
